// File: rtl/crc_frame_pkg.sv
// Shared types and default constants for the serial CRC frame transmitter.
// S_PREAMBLE exists only when CRC_FRAME_TX_PREAMBLE_EN is defined.
package crc_frame_pkg;

    typedef enum logic [1:0] {
        S_IDLE     = 2'd0,
        S_DATA     = 2'd1,
`ifdef CRC_FRAME_TX_PREAMBLE_EN
        S_CRC      = 2'd2,
        S_PREAMBLE = 2'd3
`else
        S_CRC      = 2'd2
`endif
    } state_t;

    localparam logic [4:0] DEF_POLY     = 5'b10011;
    localparam logic [3:0] DEF_SEED     = 4'h0;
    localparam logic [7:0] DEF_PREAMBLE = 8'hA5;

    function automatic int max3(input int a, input int b, input int c);
        int m;
        m = (a > b) ? a : b;
        return (m > c) ? m : c;
    endfunction

endpackage

// File: rtl/crc_serial_step.sv
// One MSB-first serial CRC step: shift left, fold in the generator when the feedback bit is set.
// Purely combinational, no handshake.
module crc_serial_step #(
    parameter int                 CRC_WIDTH = 4,
    parameter logic [CRC_WIDTH:0] POLY      = 5'b10011
) (
    input  logic [CRC_WIDTH-1:0] crc,
    input  logic                 data_bit,
    output logic [CRC_WIDTH-1:0] crc_next
);

    logic feedback;

    always_comb begin
        feedback = data_bit ^ crc[CRC_WIDTH-1];
        crc_next = (crc << 1) ^ (feedback ? POLY[CRC_WIDTH-1:0] : '0);
    end

endmodule

// File: rtl/crc_frame_tx.sv
// Serialises one payload word MSB first followed by its CRC; optional preamble under CRC_FRAME_TX_PREAMBLE_EN.
// First bit valid one cycle after accept; a bit advances only on tx_valid && tx_ready, otherwise everything holds.
module crc_frame_tx
    import crc_frame_pkg::*;
#(
    parameter int                   DATA_WIDTH = 12,
    parameter int                   CRC_WIDTH  = 4,
    parameter logic [CRC_WIDTH:0]   POLY       = DEF_POLY,
    parameter logic [CRC_WIDTH-1:0] SEED       = DEF_SEED,
    parameter logic [7:0]           PREAMBLE   = DEF_PREAMBLE
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  in_valid,
    input  logic [DATA_WIDTH-1:0] in_data,
    output logic                  in_ready,
    output logic                  tx_bit,
    output logic                  tx_valid,
    input  logic                  tx_ready,
    output logic                  tx_sof,
    output logic                  tx_eof,
    output logic                  busy
);

    localparam int CNT_W = $clog2(max3(DATA_WIDTH, CRC_WIDTH, 8) + 1);
    localparam logic [CNT_W-1:0] DATA_CNT = CNT_W'(DATA_WIDTH);
    localparam logic [CNT_W-1:0] CRC_CNT  = CNT_W'(CRC_WIDTH);
    localparam logic [CNT_W-1:0] ONE_CNT  = CNT_W'(1);

    state_t                  state;
    state_t                  state_nxt;
    logic [DATA_WIDTH-1:0]   shreg;
    logic [CRC_WIDTH-1:0]    crc;
    logic [CRC_WIDTH-1:0]    crc_step;
    logic [CNT_W-1:0]        cnt;
    logic                    accept;
    logic                    advance;
    logic                    last_bit;
`ifdef CRC_FRAME_TX_PREAMBLE_EN
    localparam logic [CNT_W-1:0] PRE_CNT = CNT_W'(8);
    logic [7:0]              pre_sreg;
`endif

    crc_serial_step #(
        .CRC_WIDTH (CRC_WIDTH),
        .POLY      (POLY)
    ) u_step (
        .crc       (crc),
        .data_bit  (shreg[DATA_WIDTH-1]),
        .crc_next  (crc_step)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= S_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        in_ready  = 1'b0;
        tx_valid  = 1'b0;
        tx_bit    = 1'b0;
        tx_sof    = 1'b0;
        tx_eof    = 1'b0;
        busy      = 1'b1;
        last_bit  = (cnt == ONE_CNT);
        case (state)
            S_IDLE: begin
                in_ready = 1'b1;
                busy     = 1'b0;
                if (in_valid) begin
`ifdef CRC_FRAME_TX_PREAMBLE_EN
                    state_nxt = S_PREAMBLE;
`else
                    state_nxt = S_DATA;
`endif
                end
            end
`ifdef CRC_FRAME_TX_PREAMBLE_EN
            S_PREAMBLE: begin
                tx_valid = 1'b1;
                tx_bit   = pre_sreg[7];
                tx_sof   = (cnt == PRE_CNT);
                if (tx_ready && last_bit) state_nxt = S_DATA;
            end
`endif
            S_DATA: begin
                tx_valid = 1'b1;
                tx_bit   = shreg[DATA_WIDTH-1];
`ifndef CRC_FRAME_TX_PREAMBLE_EN
                tx_sof   = (cnt == DATA_CNT);
`endif
                if (tx_ready && last_bit) state_nxt = S_CRC;
            end
            S_CRC: begin
                tx_valid = 1'b1;
                tx_bit   = crc[CRC_WIDTH-1];
                tx_eof   = last_bit;
                if (tx_ready && last_bit) state_nxt = S_IDLE;
            end
            default: begin
                state_nxt = S_IDLE;
            end
        endcase
        accept  = in_ready && in_valid;
        advance = tx_valid && tx_ready;
    end

    // Datapath: counter reloads at each phase boundary so it always counts bits left in the current phase.
    always_ff @(posedge clk) begin
        if (rst) begin
            shreg    <= '0;
            crc      <= SEED;
            cnt      <= '0;
`ifdef CRC_FRAME_TX_PREAMBLE_EN
            pre_sreg <= '0;
`endif
        end else if (accept) begin
            shreg    <= in_data;
            crc      <= SEED;
`ifdef CRC_FRAME_TX_PREAMBLE_EN
            pre_sreg <= PREAMBLE;
            cnt      <= PRE_CNT;
`else
            cnt      <= DATA_CNT;
`endif
        end else if (advance) begin
            case (state)
`ifdef CRC_FRAME_TX_PREAMBLE_EN
                S_PREAMBLE: begin
                    pre_sreg <= pre_sreg << 1;
                    cnt      <= last_bit ? DATA_CNT : cnt - ONE_CNT;
                end
`endif
                S_DATA: begin
                    shreg <= shreg << 1;
                    crc   <= crc_step;
                    cnt   <= last_bit ? CRC_CNT : cnt - ONE_CNT;
                end
                S_CRC: begin
                    crc <= crc << 1;
                    cnt <= cnt - ONE_CNT;
                end
                default: begin
                    cnt <= cnt;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_crc_frame_tx.sv
// Bench for crc_frame_tx: directed frames from known values plus random frames checked against a polynomial-division model.
module tb_crc_frame_tx;

    localparam int DW = 12;
    localparam int CW = 4;
`ifdef CRC_FRAME_TX_PREAMBLE_EN
    localparam int PW = 8;
    localparam logic [63:0] PRE_OFS = 64'hA5 << (DW + CW);
`else
    localparam int PW = 0;
    localparam logic [63:0] PRE_OFS = 64'h0;
`endif
    localparam int FW = PW + DW + CW;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          in_valid = 1'b0;
    logic [DW-1:0] in_data = '0;
    logic          in_ready;
    logic          tx_bit;
    logic          tx_valid;
    logic          tx_ready = 1'b1;
    logic          tx_sof;
    logic          tx_eof;
    logic          busy;

    int errors = 0;
    int checks = 0;

    crc_frame_tx #(.DATA_WIDTH(DW), .CRC_WIDTH(CW)) dut (
        .clk      (clk),
        .rst      (rst),
        .in_valid (in_valid),
        .in_data  (in_data),
        .in_ready (in_ready),
        .tx_bit   (tx_bit),
        .tx_valid (tx_valid),
        .tx_ready (tx_ready),
        .tx_sof   (tx_sof),
        .tx_eof   (tx_eof),
        .busy     (busy)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Reference: long division of d * x^CW by x^4+x+1 over GF(2), seed 0.
    function automatic logic [63:0] model_frame(input logic [DW-1:0] d);
        logic [63:0] rem;
        logic [63:0] poly;
        poly = 64'b10011;
        rem  = 64'(d) << CW;
        for (int i = DW + CW - 1; i >= CW; i--) begin
            if (rem[i]) rem = rem ^ (poly << (i - CW));
        end
        return PRE_OFS | (64'(d) << CW) | (rem & 64'hF);
    endfunction

    // Called at the negedge right after the accepting edge. mode: 0 ready, 1 toggling (stall first), 2 random.
    task automatic collect_frame(input logic [63:0] exp, input int mode, input string tag);
        logic [63:0] got;
        int n;
        int cyc;
        logic rdy;
        logic stalled;
        logic pb, ps, pe;
        logic sof_ok, eof_ok, vld_ok;
        got = '0; n = 0; cyc = 0; stalled = 1'b0;
        pb = 1'b0; ps = 1'b0; pe = 1'b0;
        sof_ok = 1'b1; eof_ok = 1'b1; vld_ok = 1'b1;
        while (n < FW && cyc < 2000) begin
            if (stalled) check({tag, "_hold"}, {61'd0, tx_bit, tx_sof, tx_eof}, {61'd0, pb, ps, pe});
            if (tx_valid !== 1'b1 || busy !== 1'b1 || in_ready !== 1'b0) vld_ok = 1'b0;
            if (tx_sof !== (n == 0)) sof_ok = 1'b0;
            if (tx_eof !== (n == FW - 1)) eof_ok = 1'b0;
            case (mode)
                0:       rdy = 1'b1;
                1:       rdy = cyc[0];
                default: rdy = 1'($urandom_range(0, 1));
            endcase
            tx_ready = rdy;
            if (rdy) begin
                got = {got[62:0], tx_bit};
                n++;
                stalled = 1'b0;
            end else begin
                stalled = 1'b1;
                pb = tx_bit; ps = tx_sof; pe = tx_eof;
            end
            cyc++;
            @(negedge clk);
        end
        tx_ready = 1'b1;
        check({tag, "_bitcount"}, 64'(n), 64'(FW));
        check({tag, "_stream"}, got, exp);
        check({tag, "_valid_busy"}, {63'd0, vld_ok}, 64'd1);
        check({tag, "_sof"}, {63'd0, sof_ok}, 64'd1);
        check({tag, "_eof"}, {63'd0, eof_ok}, 64'd1);
        check({tag, "_idle_after"}, {61'd0, in_ready, tx_valid, busy}, {61'd0, 3'b100});
        if (mode == 1) check({tag, "_cycles"}, 64'(cyc), 64'(2 * FW));
    endtask

    task automatic start_frame(input logic [DW-1:0] d);
        in_valid = 1'b1;
        in_data  = d;
        @(negedge clk);
        in_valid = 1'b0;
        in_data  = DW'($urandom);
    endtask

    initial begin
        logic [DW-1:0] rd;
        @(negedge clk);
        @(negedge clk);
        check("reset_outputs", {58'd0, in_ready, tx_valid, tx_bit, tx_sof, tx_eof, busy},
              {58'd0, 6'b100000});
        rst = 1'b0;
        @(negedge clk);
        check("idle_ready", {62'd0, in_ready, tx_valid}, {62'd0, 2'b10});

        // Directed frames with continuous ready.
        start_frame(12'h001);
        collect_frame(PRE_OFS | 64'h0013, 0, "d001");
        start_frame(12'h800);
        collect_frame(PRE_OFS | 64'h8001, 0, "d800");
        start_frame(12'h000);
        collect_frame(PRE_OFS | 64'h0000, 0, "d000");

        // Alternating backpressure.
        start_frame(12'h001);
        collect_frame(PRE_OFS | 64'h0013, 1, "stall001");

        // Back-to-back: in_valid stays high, second word must wait for the first frame to finish.
        in_valid = 1'b1;
        in_data  = 12'h001;
        @(negedge clk);
        in_data  = 12'h800;
        collect_frame(PRE_OFS | 64'h0013, 0, "b2b_first");
        @(negedge clk);
        in_valid = 1'b0;
        collect_frame(PRE_OFS | 64'h8001, 0, "b2b_second");

        // Reset mid-frame.
        start_frame(12'h001);
        repeat (PW + 4) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        check("midrst_outputs", {58'd0, in_ready, tx_valid, tx_bit, tx_sof, tx_eof, busy},
              {58'd0, 6'b100000});
        rst = 1'b0;
        repeat (3) @(negedge clk);
        check("midrst_quiet", {63'd0, tx_valid}, 64'd0);
        start_frame(12'h001);
        collect_frame(PRE_OFS | 64'h0013, 0, "after_rst");

        // Reset wins over a simultaneous accept.
        rst = 1'b1;
        in_valid = 1'b1;
        in_data = 12'h5A5;
        @(negedge clk);
        in_valid = 1'b0;
        rst = 1'b0;
        @(negedge clk);
        check("rst_over_accept", {62'd0, tx_valid, busy}, 64'd0);

        // Random payloads under random backpressure.
        for (int k = 0; k < 10; k++) begin
            rd = DW'($urandom);
            start_frame(rd);
            collect_frame(model_frame(rd), 2, "rand");
            repeat ($urandom_range(0, 2)) @(negedge clk);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
